// File: rtl/cardinal_nic_if.sv
// CPU NIC register port plus ring-router local port, bundled for cardinal_nic.
// With NIC_POLARITY_EN defined, the bundle also carries the router's polarity bit.
interface cardinal_nic_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
);
  logic [0:ADDR_WIDTH-1] nicAddr;
  logic [0:DATA_WIDTH-1] nicDataIn;
  logic [0:DATA_WIDTH-1] nicDataOut;
  logic                  nicEn;
  logic                  nicWrEn;
  logic                  net_si;
  logic                  net_ri;
  logic [0:DATA_WIDTH-1] net_di;
  logic                  net_so;
  logic                  net_ro;
  logic [0:DATA_WIDTH-1] net_do;
`ifdef NIC_POLARITY_EN
  logic                  polarity;

  modport slave (
    input  nicAddr, nicDataIn, nicEn, nicWrEn, net_si, net_di, net_ro, polarity,
    output nicDataOut, net_ri, net_so, net_do
  );
  modport master (
    output nicAddr, nicDataIn, nicEn, nicWrEn, net_si, net_di, net_ro, polarity,
    input  nicDataOut, net_ri, net_so, net_do
  );
`else
  modport slave (
    input  nicAddr, nicDataIn, nicEn, nicWrEn, net_si, net_di, net_ro,
    output nicDataOut, net_ri, net_so, net_do
  );
  modport master (
    output nicAddr, nicDataIn, nicEn, nicWrEn, net_si, net_di, net_ro,
    input  nicDataOut, net_ri, net_so, net_do
  );
`endif
endinterface

// File: rtl/cardinal_nic.sv
// Network interface: single-entry router->CPU and CPU->router buffers behind a
// memory-mapped register port. Optional macro NIC_POLARITY_EN gates net_so by polarity.
module cardinal_nic #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 2
) (
  input logic           clk,
  input logic           reset,
  cardinal_nic_if.slave nic
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} chan_state_t;

  localparam logic [0:ADDR_WIDTH-1] A_IN_BUF  = ADDR_WIDTH'(0);
  localparam logic [0:ADDR_WIDTH-1] A_IN_ST   = ADDR_WIDTH'(1);
  localparam logic [0:ADDR_WIDTH-1] A_OUT_BUF = ADDR_WIDTH'(2);
  localparam logic [0:ADDR_WIDTH-1] A_OUT_ST  = ADDR_WIDTH'(3);

  chan_state_t           in_state, in_next;
  chan_state_t           out_state, out_next;
  logic [0:DATA_WIDTH-1] in_buf, out_buf;
  logic                  cpu_rd, cpu_wr;
  logic                  in_fill, in_drain, out_load, out_drain;

  assign cpu_rd = nic.nicEn & ~nic.nicWrEn;
  assign cpu_wr = nic.nicEn &  nic.nicWrEn;

  assign nic.net_ri = (in_state == EMPTY);
`ifdef NIC_POLARITY_EN
  // Bit 1 of the packet is its virtual channel; it may only leave on the matching cycle.
  assign nic.net_so = (out_state == FULL) & (out_buf[1] == nic.polarity);
`else
  assign nic.net_so = (out_state == FULL);
`endif
  assign nic.net_do = out_buf;

  assign in_fill   = nic.net_si & nic.net_ri;
  assign in_drain  = cpu_rd & (nic.nicAddr == A_IN_BUF) & (in_state == FULL);
  // Overflowing writes are dropped; the decision uses the pre-edge occupancy.
  assign out_load  = cpu_wr & (nic.nicAddr == A_OUT_BUF) & (out_state == EMPTY);
  assign out_drain = nic.net_so & nic.net_ro;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_state  <= EMPTY;
      out_state <= EMPTY;
    end else begin
      in_state  <= in_next;
      out_state <= out_next;
    end
  end

  always_comb begin
    in_next  = in_state;
    out_next = out_state;
    case (in_state)
      EMPTY:   if (in_fill)  in_next = FULL;
      FULL:    if (in_drain) in_next = EMPTY;
      default: in_next = EMPTY;
    endcase
    case (out_state)
      EMPTY:   if (out_load)  out_next = FULL;
      FULL:    if (out_drain) out_next = EMPTY;
      default: out_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_buf  <= '0;
      out_buf <= '0;
    end else begin
      if (in_fill)  in_buf  <= nic.net_di;
      if (out_load) out_buf <= nic.nicDataIn;
    end
  end

  // Status words carry the flag in the last (least significant) bit.
  always_comb begin
    nic.nicDataOut = '0;
    if (cpu_rd) begin
      case (nic.nicAddr)
        A_IN_BUF:  nic.nicDataOut = in_buf;
        A_IN_ST:   nic.nicDataOut = {{(DATA_WIDTH-1){1'b0}}, (in_state == FULL)};
        A_OUT_BUF: nic.nicDataOut = out_buf;
        A_OUT_ST:  nic.nicDataOut = {{(DATA_WIDTH-1){1'b0}}, (out_state == FULL)};
        default:   nic.nicDataOut = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_cardinal_nic.sv
// Bench for cardinal_nic: directed steps then random traffic against a buffer model.
module tb_cardinal_nic;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cardinal_nic_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(2)) bus ();
  cardinal_nic #(.DATA_WIDTH(DW), .ADDR_WIDTH(2)) dut (.clk(clk), .reset(reset), .nic(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: each channel is "holds a packet or not" plus the last packet stored.
  logic [0:DW-1] m_in_buf, m_out_buf;
  bit            m_in_full, m_out_full;
  bit            toggle_pol = 1'b0;

  task automatic check(input string tag, input logic [0:DW-1] obs, input logic [0:DW-1] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_in_buf = '0; m_out_buf = '0; m_in_full = 0; m_out_full = 0;
  endtask

  function automatic bit exp_so();
`ifdef NIC_POLARITY_EN
    return m_out_full && (m_out_buf[1] == bus.polarity);
`else
    return m_out_full;
`endif
  endfunction

  function automatic logic [0:DW-1] exp_rd();
    if (!bus.nicEn || bus.nicWrEn) return '0;
    case (bus.nicAddr)
      2'b00:   return m_in_buf;
      2'b01:   return DW'(m_in_full);
      2'b10:   return m_out_buf;
      default: return DW'(m_out_full);
    endcase
  endfunction

  task automatic drive(input bit en, input bit we, input logic [0:1] addr,
                       input logic [0:DW-1] din, input bit si,
                       input logic [0:DW-1] di, input bit ro);
    bus.nicEn = en; bus.nicWrEn = we; bus.nicAddr = addr; bus.nicDataIn = din;
    bus.net_si = si; bus.net_di = di; bus.net_ro = ro;
  endtask

  // Check all outputs against the model mid-cycle, then advance model and DUT one edge.
  task automatic cycle(input string tag);
    bit f_in, d_in, ld, d_out;
    @(negedge clk);
    check({tag, ".ri"},   DW'(bus.net_ri), DW'(!m_in_full));
    check({tag, ".so"},   DW'(bus.net_so), DW'(exp_so()));
    check({tag, ".do"},   bus.net_do, m_out_buf);
    check({tag, ".rd"},   bus.nicDataOut, exp_rd());
    f_in  = bus.net_si && !m_in_full;
    d_in  = bus.nicEn && !bus.nicWrEn && bus.nicAddr == 2'b00 && m_in_full;
    ld    = bus.nicEn && bus.nicWrEn && bus.nicAddr == 2'b10 && !m_out_full;
    d_out = exp_so() && bus.net_ro;
    @(posedge clk);
    if (f_in)  begin m_in_buf = bus.net_di; m_in_full = 1; end
    if (d_in)  m_in_full = 0;
    if (ld)    begin m_out_buf = bus.nicDataIn; m_out_full = 1; end
    if (d_out) m_out_full = 0;
    #1;
`ifdef NIC_POLARITY_EN
    if (toggle_pol) bus.polarity = ~bus.polarity;
`endif
  endtask

  localparam logic [0:DW-1] P_IN  = 64'hDEAD_BEEF_0000_0001;
  localparam logic [0:DW-1] P_OUT = 64'h0000_0002_CAFE_F00D;
  localparam logic [0:DW-1] P_A   = 64'h0123_4567_89AB_CDEF;
  localparam logic [0:DW-1] P_B1  = 64'h0AAA_0000_0000_0001;
  localparam logic [0:DW-1] P_B2  = 64'h0BBB_0000_0000_0002;

  initial begin
    reset = 1'b1;
`ifdef NIC_POLARITY_EN
    bus.polarity = 1'b0;
`endif
    drive(0, 0, 2'b00, '0, 0, '0, 0);
    model_clear();
    #12;
    check("rst.ri", DW'(bus.net_ri), DW'(1));
    check("rst.so", DW'(bus.net_so), DW'(0));
    check("rst.do", bus.net_do, '0);
    reset = 1'b0;

    drive(1, 0, 2'b01, '0, 0, '0, 0); #2;
    check("rst.rd01", bus.nicDataOut, '0);
    cycle("rd01");
    drive(1, 0, 2'b11, '0, 0, '0, 0); #2;
    check("rst.rd11", bus.nicDataOut, '0);
    cycle("rd11");

    // Inbound packet, status, drain.
    drive(0, 0, 2'b00, '0, 1, P_IN, 0); cycle("in_push");
    drive(1, 0, 2'b01, '0, 0, '0, 0); #2;
    check("in.st1", bus.nicDataOut, DW'(1));
    check("in.ri0", DW'(bus.net_ri), DW'(0));
    cycle("in_st");
    drive(1, 0, 2'b00, '0, 0, '0, 0); #2;
    check("in.data", bus.nicDataOut, P_IN);
    cycle("in_drain");
    drive(1, 0, 2'b01, '0, 0, '0, 0); #2;
    check("in.st0", bus.nicDataOut, '0);
    check("in.ri1", DW'(bus.net_ri), DW'(1));
    cycle("in_after");

    // Outbound packet, then router drains it.
    drive(1, 1, 2'b10, P_OUT, 0, '0, 0); cycle("out_wr");
    drive(1, 0, 2'b11, '0, 0, '0, 0); #2;
    check("out.so1", DW'(bus.net_so), DW'(1));
    check("out.do", bus.net_do, P_OUT);
    check("out.st1", bus.nicDataOut, DW'(1));
    cycle("out_st");
    drive(0, 0, 2'b00, '0, 0, '0, 1); cycle("out_drain");
    drive(1, 0, 2'b11, '0, 0, '0, 0); #2;
    check("out.so0", DW'(bus.net_so), DW'(0));
    check("out.st0", bus.nicDataOut, '0);
    cycle("out_after");

    // Overflow writes, including one racing a router drain.
    drive(1, 1, 2'b10, P_A, 0, '0, 0); cycle("ovf_ld");
    drive(1, 1, 2'b10, 64'h1111, 0, '0, 0); cycle("ovf_wr");
    #2 check("ovf.keep", bus.net_do, P_A);
    drive(1, 1, 2'b10, 64'h2222, 0, '0, 1); cycle("ovf_race");
    drive(0, 0, 2'b00, '0, 0, '0, 0); #2;
    check("ovf.so0", DW'(bus.net_so), DW'(0));
    check("ovf.hold", bus.net_do, P_A);
    cycle("ovf_after");

    // Inbound backpressure: second packet waits for the CPU drain, then one more edge.
    drive(0, 0, 2'b00, '0, 1, P_B1, 0); cycle("bp_1");
    drive(0, 0, 2'b00, '0, 1, P_B2, 0); cycle("bp_hold1"); cycle("bp_hold2");
    drive(1, 0, 2'b00, '0, 1, P_B2, 0); #2;
    check("bp.first", bus.nicDataOut, P_B1);
    cycle("bp_drain");
    drive(1, 0, 2'b01, '0, 1, P_B2, 0); #2;
    check("bp.empty", bus.nicDataOut, '0);
    check("bp.ri1", DW'(bus.net_ri), DW'(1));
    cycle("bp_capture");
    drive(1, 0, 2'b00, '0, 0, '0, 0); #2;
    check("bp.second", bus.nicDataOut, P_B2);
    cycle("bp_read2");

    // Reset in the middle of a cycle with both buffers occupied.
    drive(1, 1, 2'b10, P_A, 1, P_IN, 0); cycle("pre_rst");
    drive(1, 0, 2'b10, '0, 0, '0, 0);
    #1 reset = 1'b1;
    #1;
    check("mrst.ri", DW'(bus.net_ri), DW'(1));
    check("mrst.so", DW'(bus.net_so), DW'(0));
    check("mrst.rd", bus.nicDataOut, '0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    #1;
    cycle("post_rst");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            {$urandom, $urandom}, $urandom_range(0, 1) == 1, {$urandom, $urandom},
            $urandom_range(0, 2) == 0);
      cycle("rand");
    end

`ifdef NIC_POLARITY_EN
    // Packet on virtual channel 1 may only leave on a polarity=1 cycle.
    drive(0, 0, 2'b00, '0, 0, '0, 1); cycle("pol_flush"); cycle("pol_flush2");
    bus.polarity = 1'b0;
    drive(1, 1, 2'b10, 64'h4000_0000_0000_00AA, 0, '0, 1);
    cycle("pol_ld");
    drive(0, 0, 2'b00, '0, 0, '0, 1);
    toggle_pol = 1'b1;
    for (int i = 0; i < 6; i++) cycle("pol");
    toggle_pol = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
